// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segment pattern, bit 6..0 = g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 on clk_i, tick_o marks the last count.
module tick_gen #(
  parameter int unsigned DIV = 5000,
  localparam int unsigned CW = $clog2(DIV)
) (
  input  logic          clk_i,
  input  logic          reset_n,
  input  logic          clr_i,
  output logic          tick_o,
  output logic [CW-1:0] count_o
);

  assign tick_o = (count_o == CW'(DIV - 1));

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      count_o <= '0;
    end else if (clr_i || tick_o) begin
      count_o <= '0;
    end else begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with blanking gap and
// double-buffered display value that only swaps at frame boundaries.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIV          = 5000,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_n,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_e             state;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_nxt;
  logic                    idx_wrap;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] active_val;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic [4*NUM_DIGITS-1:0] reload_val;
  logic [NUM_DIGITS-1:0]   reload_dp;
  logic [3:0]              next_nibble;
  logic                    tick;
  logic [CW-1:0]           count;
  logic                    clr;

  // Prescaler is held at 0 while idle so each scan starts on a full period.
  assign clr = !en_i || (state == IDLE);

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .reset_n(reset_n),
    .clr_i  (clr),
    .tick_o (tick),
    .count_o(count)
  );

  // A load coinciding with a reload point bypasses the shadow register.
  always_comb begin
    reload_val  = load_i ? value_i : shadow_val;
    reload_dp   = load_i ? dp_i : shadow_dp;
    idx_wrap    = (idx == IW'(NUM_DIGITS - 1));
    idx_nxt     = idx_wrap ? '0 : idx + 1'b1;
    next_nibble = active_val[4*int'(idx_nxt) +: 4];
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      seg_o      <= SEG_OFF;
      dp_o       <= 1'b1;
      an_o       <= '1;
      frame_o    <= 1'b0;
    end else begin
      frame_o <= 1'b0;
      if (load_i) begin
        shadow_val <= value_i;
        shadow_dp  <= dp_i;
      end
      if (!en_i) begin
        state <= IDLE;
        idx   <= '0;
        seg_o <= SEG_OFF;
        dp_o  <= 1'b1;
        an_o  <= '1;
      end else begin
        unique case (state)
          IDLE: begin
            state      <= BLANK;
            idx        <= '0;
            active_val <= reload_val;
            active_dp  <= reload_dp;
            seg_o      <= hex_to_seg(reload_val[3:0]);
            dp_o       <= ~reload_dp[0];
            an_o       <= '1;
          end
          BLANK: begin
            if (count == CW'(BLANK_CYCLES - 1)) begin
              state <= DRIVE;
              an_o  <= ~(NUM_DIGITS'(1) << idx);
            end
          end
          DRIVE: begin
            if (tick) begin
              state <= BLANK;
              an_o  <= '1;
              idx   <= idx_nxt;
              // Segments for the next digit are set here so they cover its blank too.
              if (idx_wrap) begin
                frame_o    <= 1'b1;
                active_val <= reload_val;
                active_dp  <= reload_dp;
                seg_o      <= hex_to_seg(reload_val[3:0]);
                dp_o       <= ~reload_dp[0];
              end else begin
                seg_o <= hex_to_seg(next_nibble);
                dp_o  <= ~active_dp[idx_nxt];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized bench for seven_seg_scan_ctrl against a time-based reference model.
module tb_seven_seg_scan_ctrl;

  localparam int unsigned DIV   = 8;
  localparam int unsigned ND    = 4;
  localparam int unsigned BC    = 2;
  localparam int unsigned FRAME = ND * DIV;

  logic        clk_i = 1'b0;
  logic        reset_n;
  logic        en_i;
  logic        load_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  always #5 clk_i = ~clk_i;

  seven_seg_scan_ctrl #(
    .DIV         (DIV),
    .NUM_DIGITS  (ND),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk_i  (clk_i),
    .reset_n(reset_n),
    .en_i   (en_i),
    .load_i (load_i),
    .value_i(value_i),
    .dp_i   (dp_i),
    .seg_o  (seg_o),
    .dp_o   (dp_o),
    .an_o   (an_o),
    .frame_o(frame_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  string ph = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: scan position is just elapsed cycles since enable.
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  bit          m_on;
  int unsigned m_t;
  logic [15:0] m_sh, m_act;
  logic [3:0]  m_shdp, m_actdp;

  function automatic int unsigned m_digit();
    return (m_t / DIV) % ND;
  endfunction

  function automatic logic [3:0] exp_an();
    if (!m_on || (m_t % DIV) < BC) return 4'hF;
    return ~(4'b0001 << m_digit());
  endfunction

  function automatic logic [6:0] exp_seg();
    logic [3:0] nib;
    if (!m_on) return 7'h7F;
    nib = 4'(m_act >> (4 * m_digit()));
    return seg_tab[nib];
  endfunction

  function automatic logic exp_dp();
    if (!m_on) return 1'b1;
    return ~m_actdp[m_digit()];
  endfunction

  function automatic logic exp_frame();
    return m_on && (m_t != 0) && (m_t % FRAME == 0);
  endfunction

  task automatic model_reset();
    m_on = 0; m_t = 0; m_sh = '0; m_act = '0; m_shdp = '0; m_actdp = '0;
  endtask

  task automatic model_clock();
    if (!en_i) begin
      m_on = 0;
    end else if (!m_on) begin
      m_on = 1;
      m_t = 0;
      m_act   = load_i ? value_i : m_sh;
      m_actdp = load_i ? dp_i : m_shdp;
    end else begin
      m_t++;
      if (m_t % FRAME == 0) begin
        m_act   = load_i ? value_i : m_sh;
        m_actdp = load_i ? dp_i : m_shdp;
      end
    end
    if (load_i) begin
      m_sh   = value_i;
      m_shdp = dp_i;
    end
  endtask

  task automatic check_all();
    check($sformatf("%s.an", ph), 32'(an_o), 32'(exp_an()));
    check($sformatf("%s.seg", ph), 32'(seg_o), 32'(exp_seg()));
    check($sformatf("%s.dp", ph), 32'(dp_o), 32'(exp_dp()));
    check($sformatf("%s.frame", ph), 32'(frame_o), 32'(exp_frame()));
  endtask

  task automatic step();
    @(posedge clk_i);
    if (reset_n) model_clock();
    @(negedge clk_i);
    check_all();
  endtask

  task automatic wait_frame(input string tag);
    int k = 0;
    while (frame_o !== 1'b1 && k < 64) begin
      step();
      k++;
    end
    check(tag, 32'(frame_o), 32'h1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; en_i = 1'b0; load_i = 1'b0; value_i = '0; dp_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    en_i = 1'b1;
    #1;
    check("reset.an", 32'(an_o), 32'hF);
    check("reset.seg", 32'(seg_o), 32'h7F);
    check("reset.dp", 32'(dp_o), 32'h1);
    check("reset.frame", 32'(frame_o), 32'h0);
    @(negedge clk_i);
    en_i = 1'b0;
    reset_n = 1'b1;
    step();

    ph = "enable";
    value_i = 16'h1234; dp_i = 4'b0001; load_i = 1'b1;
    step();
    load_i = 1'b0; en_i = 1'b1;
    repeat (3) step();
    check("first.an", 32'(an_o), 32'hE);
    check("first.seg", 32'(seg_o), 32'h19);
    check("first.dp", 32'(dp_o), 32'h0);

    ph = "cadence";
    wait_frame("frame_first");
    n = 0;
    do begin
      step();
      n++;
    end while (frame_o !== 1'b1 && n < 64);
    check("frame_period", 32'(n), 32'd32);

    ph = "tear";
    for (int i = 0; i < 64 && !(m_digit() == 1 && m_t % DIV == 3); i++) step();
    value_i = 16'hABCD; dp_i = 4'b0000; load_i = 1'b1;
    step();
    load_i = 1'b0;
    wait_frame("tear_frame");
    check("tear.seg_d", 32'(seg_o), 32'h21);

    ph = "wrap_load";
    for (int i = 0; i < 64 && (m_t % FRAME) != FRAME - 1; i++) step();
    value_i = 16'h0008; load_i = 1'b1;
    step();
    load_i = 1'b0;
    check("wrap.frame", 32'(frame_o), 32'h1);
    check("wrap.seg8", 32'(seg_o), 32'h00);

    ph = "disable";
    for (int i = 0; i < 64 && !(m_digit() == 2 && m_t % DIV == 4); i++) step();
    check("dis.pre_an", 32'(an_o), 32'hB);
    en_i = 1'b0;
    step();
    check("dis.an", 32'(an_o), 32'hF);
    check("dis.seg", 32'(seg_o), 32'h7F);
    en_i = 1'b1;
    repeat (2) step();
    check("reen.blank", 32'(an_o), 32'hF);
    step();
    check("reen.an", 32'(an_o), 32'hE);
    check("reen.seg", 32'(seg_o), 32'h00);

    ph = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) en_i = ~en_i;
      else if (!en_i && $urandom_range(0, 3) == 0) en_i = 1'b1;
      load_i  = ($urandom_range(0, 15) == 0);
      value_i = 16'($urandom);
      dp_i    = 4'($urandom);
      step();
      if (i == 1500) begin
        en_i = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst.an", 32'(an_o), 32'hF);
        check("async_rst.seg", 32'(seg_o), 32'h7F);
        check("async_rst.dp", 32'(dp_o), 32'h1);
        check("async_rst.frame", 32'(frame_o), 32'h0);
        model_reset();
        @(negedge clk_i);
        reset_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for the multi-digit seven-segment display on the lab board. It divides `clk_i` into a digit-rate tick and sequences the shared segment bus across the digit anodes. It inserts a blanking gap between digits to prevent ghosting, and double-buffers the displayed value so that updates never tear mid-frame. It sits between the user datapath, which supplies hex nibbles, and the board's segment and anode pins.

## Interface
- `DIV`, 5000: digit period in `clk_i` cycles (tick rate); must be ≥ 2.
- `NUM_DIGITS`, 4: number of digits scanned.
- `BLANK_CYCLES`, 2: cycles at the start of each digit period with all anodes off; must be < `DIV`.
- `clk_i`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  display enable; low forces blank and the idle state.
- `load_i`  in  1  single-cycle strobe; capture `value_i`/`dp_i` into the shadow register.
- `value_i`  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k (digit 0 = LS nibble).
- `dp_i`  in  NUM_DIGITS  decimal points; bit k drives digit k.
- `seg_o`  out  7  segments, active-low, bit 6..0 = g..a.
- `dp_o`  out  1  decimal point, active-low.
- `an_o`  out  NUM_DIGITS  digit anodes, active-low, one-hot-low or all high.
- `frame_o`  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

## Operation
- **Reset values:** `an_o` = all 1, `seg_o` = 7'h7F, `dp_o` = 1, `frame_o` = 0. The prescaler, digit index, shadow register and active register all reset to 0. State resets to IDLE.
- **States:**
  - IDLE: anodes off, prescaler held at 0.
  - BLANK: anodes off; `seg_o`/`dp_o` already show the current digit.
  - DRIVE: `an_o[idx]` = 0.
- **Transitions:**
  - IDLE→BLANK when `en_i` = 1. On entry, idx = 0, the prescaler starts from 0, and active ← shadow.
  - BLANK→DRIVE when the prescaler reaches `BLANK_CYCLES`-1.
  - DRIVE→BLANK on tick (prescaler = `DIV`-1). On this transition the prescaler wraps to 0 and idx increments, wrapping from `NUM_DIGITS`-1 to 0.
  - Any state→IDLE on the cycle after `en_i` = 0. Outputs go inactive and idx returns to 0.
- **Frame wrap:** on the tick where idx wraps to 0, `frame_o` = 1 for one cycle and active ← shadow.
- **Loading:**
  - `load_i` writes the shadow register only. Active updates only at frame wrap or on IDLE exit.
  - If `load_i` coincides with a frame wrap, `value_i` goes directly to active.
- **Decode:** hex 0–F to the standard seven-segment pattern, e.g. 0=7'h40, 4=7'h19, 8=7'h00, A=7'h08, D=7'h21.

## Timing
- `seg_o`, `dp_o`, `an_o` and `frame_o` are all registered outputs.
- Each digit period is exactly `DIV` cycles: `BLANK_CYCLES` with anodes off, then `DIV`-`BLANK_CYCLES` with the anode on. A full frame is `NUM_DIGITS`·`DIV` cycles.
- After `en_i` rises, the first anode goes low `BLANK_CYCLES`+1 cycles later.
- `en_i` falling mid-DRIVE: anodes are off on the next cycle. There is no partial-digit completion.
- The segment pattern for a digit is stable for the whole digit period, including its blank.
- `reset_n` asserted mid-frame: outputs take their reset values immediately (asynchronous).

## Structure
- Package `seven_seg_pkg` holds:
  - the state enum (IDLE, BLANK, DRIVE);
  - `SEG_OFF` = 7'h7F;
  - the `hex_to_seg` decode function.
- Sub-module `tick_gen` (parameter `DIV`; ports `clk_i`, `reset_n`, `clr_i`, `tick_o`, `count_o`) is the free-running prescaler. It replaces ad-hoc divided clocks; everything runs on `clk_i` with enables.
- The FSM, index, shadow/active registers and output registers live in the top module.

## Test plan
Bench parameters: `DIV`=8, `BLANK_CYCLES`=2, `NUM_DIGITS`=4.

- **Reset:** assert `reset_n`=0 with `en_i`=1 → `an_o`=4'hF, `seg_o`=7'h7F, `dp_o`=1, `frame_o`=0.
- **Enable and first digit:** `load_i` with `value_i`=16'h1234 and `dp_i`=4'b0001, then `en_i`=1 → after 3 cycles `an_o`=4'hE, `seg_o`=7'h19, `dp_o`=0.
- **Scan cadence:** per digit, `an_o`=4'hF for 2 cycles then low for 6. Digits show 4,3,2,1 with `an_o` = E,D,B,7. `frame_o` pulses every 32 cycles.
- **No tearing:** `load_i` with 16'hABCD during digit 1 → digits 2 and 3 still show 2 and 1. After `frame_o`, digit 0 shows D (7'h21).
- **Load at wrap:** `load_i` with 16'h0008 on the `frame_o` cycle → the next digit 0 shows 8 (7'h00).
- **Disable and re-enable:** `en_i`=0 mid-DRIVE of digit 2 → next cycle `an_o`=4'hF and `seg_o`=7'h7F. Re-enable → the scan restarts at digit 0 after a 2-cycle blank.
